kbd_entry_ctrl: RTL

- Sequencer for the kbd_if keyboard datapath.
- Watches kbd_if's key output, acknowledges each scancode with a one-cycle shift pulse, and filters PS/2 set-2 break (F0) and extended (E0) prefixes.
- Assembles typed digits into a 4-digit BCD HH:MM entry buffer.
- Commits the validated entry to the alarm or time registers on the 'A' and 'T' keys. Sits between kbd_if and the alarm-clock core.

---
 rtl/kbd_entry_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/kbd_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kbd_entry_ctrl
// Description : Scancode sequencer for kbd_if. Acknowledges codes, filters
//               set-2 break/extended prefixes, assembles a BCD HH:MM entry
//               and commits it to the alarm or time register.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_entry_ctrl #(
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic        clk256,
    input  logic        reset,
    input  logic [7:0]  key,
    output logic        shift,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic [15:0] alarm_value,
    output logic [15:0] time_value,
    output logic        load_alarm,
    output logic        load_time,
    output logic        entry_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACK   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_EXEC  = 2'd3;

    localparam logic [7:0] C_TIMEOUT   = 8'(DRAIN_TIMEOUT);
    localparam logic [7:0] C_EXTENDED  = 8'hE0;
    localparam logic [7:0] C_BREAK     = 8'hF0;
    localparam logic [7:0] C_BACKSPACE = 8'h66;
    localparam logic [7:0] C_ESC       = 8'h76;
    localparam logic [7:0] C_KEY_A     = 8'h1C;
    localparam logic [7:0] C_KEY_T     = 8'h2C;

    logic [1:0]  r_state,  w_state;
    logic [7:0]  r_code,   w_code;
    logic [7:0]  r_cnt,    w_cnt;
    logic        r_break,  w_break;
    logic        r_shift,  w_shift;
    logic [15:0] r_digits, w_digits;
    logic [2:0]  r_count,  w_count;
    logic [15:0] r_alarm,  w_alarm;
    logic [15:0] r_time,   w_time;
    logic        r_load_a, w_load_a;
    logic        r_load_t, w_load_t;
    logic        r_err,    w_err;
    logic        r_busy,   w_busy;

    logic        w_dig_hit;
    logic [3:0]  w_dig_val;
    logic        w_entry_ok;
    logic [7:0]  w_cnt_inc;

    always_comb begin
        w_dig_hit = 1'b1;
        w_dig_val = 4'd0;
        case (r_code)
            8'h45:   w_dig_val = 4'd0;
            8'h16:   w_dig_val = 4'd1;
            8'h1E:   w_dig_val = 4'd2;
            8'h26:   w_dig_val = 4'd3;
            8'h25:   w_dig_val = 4'd4;
            8'h2E:   w_dig_val = 4'd5;
            8'h36:   w_dig_val = 4'd6;
            8'h3D:   w_dig_val = 4'd7;
            8'h3E:   w_dig_val = 4'd8;
            8'h46:   w_dig_val = 4'd9;
            default: w_dig_hit = 1'b0;
        endcase
    end

    // Nibbles only ever hold 0..9, so a plain byte compare is a BCD compare.
    assign w_entry_ok = (r_count == 3'd4) && (r_digits[15:8] <= 8'h23) &&
                        (r_digits[7:0] <= 8'h59);
    assign w_cnt_inc  = r_cnt + 8'd1;

    always_comb begin
        w_state  = r_state;
        w_code   = r_code;
        w_cnt    = r_cnt;
        w_break  = r_break;
        w_digits = r_digits;
        w_count  = r_count;
        w_alarm  = r_alarm;
        w_time   = r_time;
        w_shift  = 1'b0;
        w_load_a = 1'b0;
        w_load_t = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key != 8'h00) begin
                    w_code  = key;
                    w_state = S_ACK;
                end
            end
            S_ACK: begin
                w_shift = 1'b1;
                w_cnt   = 8'd0;
                w_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (key == 8'h00) begin
                    w_state = S_EXEC;
                end else begin
                    w_cnt = w_cnt_inc;
                    // Stuck code: re-acknowledge, but keep r_code so it runs once.
                    if (w_cnt_inc == C_TIMEOUT) begin
                        w_err   = 1'b1;
                        w_state = S_ACK;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                if (r_code == C_EXTENDED) begin
                    w_break = r_break;
                end else if (r_code == C_BREAK) begin
                    w_break = 1'b1;
                end else if (r_break) begin
                    w_break = 1'b0;
                end else if (w_dig_hit) begin
                    w_digits = {r_digits[11:0], w_dig_val};
                    w_count  = (r_count == 3'd4) ? 3'd4 : r_count + 3'd1;
                end else if (r_code == C_BACKSPACE) begin
                    w_digits = {4'h0, r_digits[15:4]};
                    w_count  = (r_count == 3'd0) ? 3'd0 : r_count - 3'd1;
                end else if (r_code == C_ESC) begin
                    w_digits = 16'h0000;
                    w_count  = 3'd0;
                end else if ((r_code == C_KEY_A) || (r_code == C_KEY_T)) begin
                    if (w_entry_ok) begin
                        if (r_code == C_KEY_A) begin
                            w_alarm  = r_digits;
                            w_load_a = 1'b1;
                        end else begin
                            w_time   = r_digits;
                            w_load_t = 1'b1;
                        end
                        w_digits = 16'h0000;
                        w_count  = 3'd0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk256) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_code   <= 8'h00;
            r_cnt    <= 8'd0;
            r_break  <= 1'b0;
            r_shift  <= 1'b0;
            r_digits <= 16'h0000;
            r_count  <= 3'd0;
            r_alarm  <= 16'h0000;
            r_time   <= 16'h0000;
            r_load_a <= 1'b0;
            r_load_t <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_code   <= w_code;
            r_cnt    <= w_cnt;
            r_break  <= w_break;
            r_shift  <= w_shift;
            r_digits <= w_digits;
            r_count  <= w_count;
            r_alarm  <= w_alarm;
            r_time   <= w_time;
            r_load_a <= w_load_a;
            r_load_t <= w_load_t;
            r_err    <= w_err;
            r_busy   <= w_busy;
        end
    end

    assign shift       = r_shift;
    assign digits      = r_digits;
    assign digit_count = r_count;
    assign alarm_value = r_alarm;
    assign time_value  = r_time;
    assign load_alarm  = r_load_a;
    assign load_time   = r_load_t;
    assign entry_err   = r_err;
    assign busy        = r_busy;

endmodule
`default_nettype wire
